// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   dmem_state_t      : responder FSM state (IDLE, WAIT, RESP)
//   dmem_req_t        : one latched bus request (addr, wdata, wstrb, wen)
//   DMEM_DEFAULT_BASE : default byte address of RAM word 0
//   DMEM_STRB_W       : byte-lane strobe width
//   DMEM_DATA_W       : data word width
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [31:0] DMEM_DEFAULT_BASE = 32'h8000_0000;
  localparam int          DMEM_STRB_W       = 4;
  localparam int          DMEM_DATA_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic [31:0]              addr;
    logic [DMEM_DATA_W-1:0]   wdata;
    logic [DMEM_STRB_W-1:0]   wstrb;
    logic                     wen;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Single-outstanding load/store bus between the core data port and the
// responder.
//   master (core)      : drives mem_addr, mem_wdata, mem_wstrb, mem_wen,
//                        mem_valid; receives mem_ready, mem_rdata, bus_err,
//                        proto_err
//   slave  (responder) : the mirror image
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_pkg::*;

  logic [31:0]            mem_addr;
  logic [DMEM_DATA_W-1:0] mem_wdata;
  logic [DMEM_STRB_W-1:0] mem_wstrb;
  logic                   mem_wen;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [DMEM_DATA_W-1:0] mem_rdata;
  logic                   bus_err;
  logic                   proto_err;

  modport master (
    output mem_addr, mem_wdata, mem_wstrb, mem_wen, mem_valid,
    input  mem_ready, mem_rdata, bus_err, proto_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wstrb, mem_wen, mem_valid,
    output mem_ready, mem_rdata, bus_err, proto_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port, synchronous-read, byte-lane-write RAM of DEPTH_WORDS x 32.
//   clk   : rising-edge clock
//   en    : access enable for this cycle
//   we    : 1 = write the strobed lanes, 0 = read word into rdata
//   wstrb : byte-lane write enables (bit n -> wdata[8n+7:8n])
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, updated only by a read access
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [DMEM_STRB_W-1:0]         wstrb,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DMEM_DATA_W-1:0]         wdata,
  output logic [DMEM_DATA_W-1:0]         rdata
);

  logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset branch so it maps onto a RAM macro;
  // contents are undefined until written.
  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int lane = 0; lane < DMEM_STRB_W; lane++) begin
          if (wstrb[lane]) begin
            mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder: latches a one-cycle request, waits LATENCY-1 cycles,
// commits the write / fetches the read on the edge entering RESP and returns a
// one-cycle mem_ready with mem_rdata valid in that cycle.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   bus     : dmem_responder_if.slave (request in, ready/rdata/errors out)
// Parameters: DEPTH_WORDS (power of two), BASE_ADDR, LATENCY (1..15).
// Build option: DMEM_RANGE_CHECK_EN -- out-of-range accesses complete with
// bus_err=1, suppressed write and zero rdata; otherwise the index aliases
// modulo DEPTH_WORDS and bus_err is tied low.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = DMEM_DEFAULT_BASE,
  parameter int          LATENCY     = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LOAD_CNT = 4'(LATENCY - 1);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  dmem_state_t state, state_nxt;
  logic [3:0]  wait_cnt;
  dmem_req_t   req_q, acc;

  logic [31:0]            offset;
  logic                   in_range, acc_err;
  logic [IDX_W-1:0]       idx;
  logic                   go_resp, arr_en, arr_we;
  logic                   ready_nxt, rd_resp_nxt, berr_nxt, perr_nxt;
  logic                   ready_q, rd_resp_q, berr_q, perr_q;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  logic                   unused_bits;

  // Access fields: with LATENCY=1 the array is hit on the same edge that
  // samples the request, so IDLE reads straight from the bus.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned
    // (which would infer a latch).
    acc = req_q;
    if (state == IDLE) begin
      acc = '{addr: bus.mem_addr, wdata: bus.mem_wdata,
              wstrb: bus.mem_wstrb, wen: bus.mem_wen};
    end
  end

  assign offset   = acc.addr - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign in_range = {1'b0, offset} < SPAN;

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_err     = ~in_range;
  assign unused_bits = ^offset[1:0];
`else
  assign acc_err     = 1'b0;
  assign unused_bits = ^{offset[1:0], in_range};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.mem_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: array strobes and next values of the registered outputs
  always_comb begin
    go_resp     = (state_nxt == RESP) && (state != RESP);
    // A reset sampled on the entering edge discards the request entirely.
    arr_en      = go_resp && !reset && !acc_err;
    arr_we      = arr_en && acc.wen;
    ready_nxt   = go_resp;
    rd_resp_nxt = go_resp && !acc.wen && !acc_err;
    berr_nxt    = go_resp && acc_err;
    perr_nxt    = bus.mem_valid && (state != IDLE);
  end

  // Request latch, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      wait_cnt  <= '0;
      ready_q   <= 1'b0;
      rd_resp_q <= 1'b0;
      berr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.mem_valid) begin
        req_q    <= acc;
        wait_cnt <= LOAD_CNT;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      ready_q   <= ready_nxt;
      rd_resp_q <= rd_resp_nxt;
      berr_q    <= berr_nxt;
      perr_q    <= perr_nxt;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .wstrb (acc.wstrb),
    .idx   (idx),
    .wdata (acc.wdata),
    .rdata (arr_rdata)
  );

  // The RAM output register holds its last read; only expose it in a read RESP.
  assign bus.mem_rdata = rd_resp_q ? arr_rdata : '0;
  assign bus.mem_ready = ready_q;
  assign bus.bus_err   = berr_q;
  assign bus.proto_err = perr_q;

endmodule
